health_round_manager: RTL and testbench
=======================================

# health_round_manager

Parametrised health and round controller for the two-player fight core, and the successor to the single-round health tracker. It applies per-attack-level damage with saturation, enforces invulnerability frames after every accepted hit, and detects KO and double KO. It runs a best-of-N round sequence with a KO hold period. It sits between the hit-detection logic and the HUD/renderer, which consume `health_1`, `health_2`, `state` and the round counters.

## Interface
Parameters:
- `HEALTH_W`, 9: width of the health registers.
- `HEALTH_MAX`, 400: start-of-round health. Must fit in `HEALTH_W` bits.
- `DMG_LIGHT` / `DMG_MED` / `DMG_HEAVY`, 4 / 10 / 20: damage for attack codes 01 / 10 / 11.
- `IFRAMES`, 30: invulnerability length in frame ticks, range 1..255.
- `KO_HOLD`, 120: frame ticks spent in a round-end state, range 1..255.
- `ROUNDS_TO_WIN`, 2: rounds needed to win the match, range 1..3.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `hit_p1`, in, 1: player 1's hitbox overlaps player 2.
- `hit_p2`, in, 1: player 2's hitbox overlaps player 1.
- `attack_p1`, in, 2: player 1 attack level; 00 means none.
- `attack_p2`, in, 2: player 2 attack level; 00 means none.
- `match_restart`, in, 1: synchronous restart request, honoured only in the MATCH states.
- `block_p1`, `block_p2`, in, 1 each: guard inputs. Present only with `HRM_BLOCK_EN`.
- `health_1`, `health_2`, out, `HEALTH_W`: current health of each player.
- `state`, out, 3: game state (encodings under Operation).
- `rounds_1`, `rounds_2`, out, 2: rounds won by each player.
- `invuln_1`, `invuln_2`, out, 1: the player is inside invulnerability frames.
- `ko_pulse`, out, 1: one-cycle strobe on entry to any round-end state.

## Operation
- States:
  - FIGHT = 000
  - ROUND_P1 = 001
  - ROUND_P2 = 010
  - ROUND_DRAW = 011
  - MATCH_P1 = 101
  - MATCH_P2 = 110
- Accepted hit on player 2 requires all of: `hit_p1`=1, `attack_p1`≠00, `state`=FIGHT, `invuln_2`=0, `health_2`>0. The rule for player 1 is the mirror image.
- On an accepted hit:
  - `health_x` ← max(`health_x` − dmg, 0), using the full-width compare; it never wraps.
  - The victim's invulnerability counter loads `IFRAMES`.
- The invulnerability counter decrements on `frame_tick` while nonzero. `invuln_x` = (counter ≠ 0).
- Holding a hit input never causes repeat damage inside the invulnerability window.
- Simultaneous accepted hits on both players are both applied in the same cycle.
- FIGHT exits, evaluated on registered health:
  - Both healths 0: go to ROUND_DRAW; no round is awarded.
  - Only `health_2`=0: go to ROUND_P1; `rounds_1` increments.
  - Only `health_1`=0: go to ROUND_P2; `rounds_2` increments.
- Round-end states (ROUND_*):
  - The hold counter loads `KO_HOLD` on entry and decrements on `frame_tick`.
  - Hits are ignored.
  - When the counter reaches 0 and the winner's round count equals `ROUNDS_TO_WIN`, go to MATCH_P1 or MATCH_P2.
  - Otherwise, start a new round: both healths ← `HEALTH_MAX`, both invulnerability counters ← 0, state ← FIGHT.
- MATCH states are sticky and ignore hits. `match_restart`=1 returns the block to full reset values.
- `match_restart` is ignored in every other state.

## Timing
- Reset values:
  - `health_1` = `health_2` = `HEALTH_MAX`
  - `state` = FIGHT
  - `rounds_1` = `rounds_2` = 0
  - `invuln_1` = `invuln_2` = 0
  - `ko_pulse` = 0
  - all counters = 0
- Asserting `reset_n` low at any time, including mid-round or mid-hold, forces the reset values immediately.
- Hit inputs are sampled at a `clk` edge. The reduced health and asserted `invuln` are visible after that same edge, i.e. 1-cycle latency.
- The KO state transition and `ko_pulse` occur one cycle after health reaches 0. `ko_pulse` is high for exactly one cycle.
- A `frame_tick` coincident with an accepted hit loads `IFRAMES` and does not decrement it.
- A new round begins on the cycle after the hold counter reaches 0.

## Configuration
- `HRM_BLOCK_EN` defined:
  - `block_p1` and `block_p2` exist.
  - A hit on a blocking player deals chip damage of dmg>>2 (1 / 2 / 5) and does not load invulnerability frames.
- `HRM_BLOCK_EN` undefined: the block ports are absent and every accepted hit deals full damage.

## Test plan
- Reset, then one cycle of `hit_p1`=1 with `attack_p1`=11: `health_2`=380 next cycle, `invuln_2`=1.
- Hold that hit for 29 frame ticks: `health_2` stays 380. After the 30th tick `invuln_2`=0 and the hit lands again: `health_2`=360.
- With `health_2`=3, apply a 10-damage hit: `health_2`=0 with no wrap. Next cycle `state`=001, `ko_pulse` pulses once, `rounds_1`=1. After 120 ticks both healths are 400 and `state`=000.
- Both players at 4 HP, simultaneous light hits: `state`=011, both round counts unchanged.
- Player 1 wins a second round: `state`=101 after the hold and stays there. `match_restart` returns `state`=000 with all rounds 0. Dropping `reset_n` low mid-hold also returns the reset values.
- `HRM_BLOCK_EN` defined, `block_p2`=1, heavy hit: `health_2`=395, `invuln_2`=0.

Source files
------------

// File: rtl/health_round_manager.sv
// Two-player health, invulnerability frames, KO detection and best-of-N rounds.
// Define HRM_BLOCK_EN to add block_p1/block_p2 guard inputs (chip damage, no i-frames).
module health_round_manager #(
  parameter int HEALTH_W      = 9,
  parameter int HEALTH_MAX    = 400,
  parameter int DMG_LIGHT     = 4,
  parameter int DMG_MED       = 10,
  parameter int DMG_HEAVY     = 20,
  parameter int IFRAMES       = 30,
  parameter int KO_HOLD       = 120,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                hit_p1,
  input  logic                hit_p2,
  input  logic [1:0]          attack_p1,
  input  logic [1:0]          attack_p2,
  input  logic                match_restart,
`ifdef HRM_BLOCK_EN
  input  logic                block_p1,
  input  logic                block_p2,
`endif
  output logic [HEALTH_W-1:0] health_1,
  output logic [HEALTH_W-1:0] health_2,
  output logic [2:0]          state,
  output logic [1:0]          rounds_1,
  output logic [1:0]          rounds_2,
  output logic                invuln_1,
  output logic                invuln_2,
  output logic                ko_pulse
);

  typedef enum logic [2:0] {
    S_FIGHT = 3'b000,
    S_RP1   = 3'b001,
    S_RP2   = 3'b010,
    S_DRAW  = 3'b011,
    S_MP1   = 3'b101,
    S_MP2   = 3'b110
  } st_e;

  localparam logic [HEALTH_W-1:0] HP_MAX =
    HEALTH_W'(HEALTH_MAX);
  localparam logic [7:0] IF_LD   = 8'(IFRAMES);
  localparam logic [7:0] HOLD_LD = 8'(KO_HOLD);
  localparam logic [1:0] RTW     = 2'(ROUNDS_TO_WIN);

  st_e                 st_q;
  st_e                 st_d;
  logic [HEALTH_W-1:0] hp1_q;
  logic [HEALTH_W-1:0] hp2_q;
  logic [HEALTH_W-1:0] hp1_d;
  logic [HEALTH_W-1:0] hp2_d;
  logic [7:0]          iv1_q;
  logic [7:0]          iv2_q;
  logic [7:0]          iv1_d;
  logic [7:0]          iv2_d;
  logic [7:0]          hold_q;
  logic [7:0]          hold_d;
  logic [1:0]          r1_q;
  logic [1:0]          r2_q;
  logic [1:0]          r1_d;
  logic [1:0]          r2_d;
  logic                ko_q;

  logic                blk1;
  logic                blk2;
  logic                acc1;
  logic                acc2;
  logic [HEALTH_W-1:0] dmg1;
  logic [HEALTH_W-1:0] dmg2;
  logic                ko1;
  logic                ko2;
  logic                in_round;
  logic                in_match;
  logic                enter_round;
  logic                new_round;
  logic                restart;

`ifdef HRM_BLOCK_EN
  assign blk1 = block_p1;
  assign blk2 = block_p2;
`else
  assign blk1 = 1'b0;
  assign blk2 = 1'b0;
`endif

  function automatic logic [HEALTH_W-1:0] dmg_of(
    input logic [1:0] atk,
    input logic       guard
  );
    logic [HEALTH_W-1:0] d;
    case (atk)
      2'b01:   d = HEALTH_W'(DMG_LIGHT);
      2'b10:   d = HEALTH_W'(DMG_MED);
      2'b11:   d = HEALTH_W'(DMG_HEAVY);
      default: d = '0;
    endcase
    return guard ? (d >> 2) : d;
  endfunction

  // Saturating subtract; health never wraps below zero.
  function automatic logic [HEALTH_W-1:0] sat_sub(
    input logic [HEALTH_W-1:0] h,
    input logic [HEALTH_W-1:0] d
  );
    return (h > d) ? (h - d) : '0;
  endfunction

  function automatic logic [7:0] tick_dec(
    input logic [7:0] c,
    input logic       tk
  );
    return (tk && (c != 8'd0)) ? (c - 8'd1) : c;
  endfunction

  assign dmg1 = dmg_of(attack_p2, blk1);
  assign dmg2 = dmg_of(attack_p1, blk2);

  assign acc2 = hit_p1 && (attack_p1 != 2'b00)
             && (st_q == S_FIGHT)
             && (iv2_q == 8'd0)
             && (hp2_q != '0);
  assign acc1 = hit_p2 && (attack_p2 != 2'b00)
             && (st_q == S_FIGHT)
             && (iv1_q == 8'd0)
             && (hp1_q != '0);

  assign ko1 = (hp1_q == '0);
  assign ko2 = (hp2_q == '0);

  assign in_round = st_q inside {S_RP1, S_RP2, S_DRAW};
  assign in_match = st_q inside {S_MP1, S_MP2};

  assign enter_round = (st_q == S_FIGHT)
                    && (st_d != S_FIGHT);
  assign new_round   = in_round && (st_d == S_FIGHT);
  assign restart     = in_match && match_restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= S_FIGHT;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_FIGHT: begin
        if (ko1 && ko2) begin
          st_d = S_DRAW;
        end else if (ko2) begin
          st_d = S_RP1;
        end else if (ko1) begin
          st_d = S_RP2;
        end
      end
      S_RP1: begin
        if (hold_q == 8'd0) begin
          st_d = (r1_q == RTW) ? S_MP1 : S_FIGHT;
        end
      end
      S_RP2: begin
        if (hold_q == 8'd0) begin
          st_d = (r2_q == RTW) ? S_MP2 : S_FIGHT;
        end
      end
      S_DRAW: begin
        if (hold_q == 8'd0) begin
          st_d = S_FIGHT;
        end
      end
      S_MP1,
      S_MP2: begin
        if (match_restart) begin
          st_d = S_FIGHT;
        end
      end
      default: st_d = S_FIGHT;
    endcase
  end

  always_comb begin
    state    = st_q;
    health_1 = hp1_q;
    health_2 = hp2_q;
    rounds_1 = r1_q;
    rounds_2 = r2_q;
    invuln_1 = (iv1_q != 8'd0);
    invuln_2 = (iv2_q != 8'd0);
    ko_pulse = ko_q;
  end

  always_comb begin
    hp1_d  = acc1 ? sat_sub(hp1_q, dmg1) : hp1_q;
    hp2_d  = acc2 ? sat_sub(hp2_q, dmg2) : hp2_q;
    // A tick in the same cycle as a hit is absorbed by the reload.
    iv1_d  = (acc1 && !blk1) ? IF_LD
           : tick_dec(iv1_q, frame_tick);
    iv2_d  = (acc2 && !blk2) ? IF_LD
           : tick_dec(iv2_q, frame_tick);
    hold_d = tick_dec(hold_q, frame_tick);
    r1_d   = r1_q;
    r2_d   = r2_q;
    if (enter_round) begin
      hold_d = HOLD_LD;
      if (st_d == S_RP1) begin
        r1_d = r1_q + 2'd1;
      end
      if (st_d == S_RP2) begin
        r2_d = r2_q + 2'd1;
      end
    end
    if (new_round || restart) begin
      hp1_d = HP_MAX;
      hp2_d = HP_MAX;
      iv1_d = 8'd0;
      iv2_d = 8'd0;
    end
    if (restart) begin
      r1_d   = 2'd0;
      r2_d   = 2'd0;
      hold_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hp1_q  <= HP_MAX;
      hp2_q  <= HP_MAX;
      iv1_q  <= 8'd0;
      iv2_q  <= 8'd0;
      hold_q <= 8'd0;
      r1_q   <= 2'd0;
      r2_q   <= 2'd0;
      ko_q   <= 1'b0;
    end else begin
      hp1_q  <= hp1_d;
      hp2_q  <= hp2_d;
      iv1_q  <= iv1_d;
      iv2_q  <= iv2_d;
      hold_q <= hold_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      ko_q   <= enter_round;
    end
  end

endmodule

// File: tb/tb_health_round_manager.sv
// Bench for health_round_manager: directed round/match sequence plus random
// stimulus, all checked every cycle against a behavioural game model.
module tb_health_round_manager;

  localparam int HMAX = 400;
  localparam int IFR  = 30;
  localparam int HOLD = 120;
  localparam int RTW  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       hit_p1;
  logic       hit_p2;
  logic [1:0] attack_p1;
  logic [1:0] attack_p2;
  logic       match_restart;
  logic       block_p1;
  logic       block_p2;
  logic [8:0] health_1;
  logic [8:0] health_2;
  logic [2:0] state;
  logic [1:0] rounds_1;
  logic [1:0] rounds_2;
  logic       invuln_1;
  logic       invuln_2;
  logic       ko_pulse;

  int checks = 0;
  int errors = 0;

  int m_hp1, m_hp2, m_iv1, m_iv2;
  int m_hold, m_st, m_r1, m_r2, m_ko;

  health_round_manager dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .hit_p1        (hit_p1),
    .hit_p2        (hit_p2),
    .attack_p1     (attack_p1),
    .attack_p2     (attack_p2),
    .match_restart (match_restart),
`ifdef HRM_BLOCK_EN
    .block_p1      (block_p1),
    .block_p2      (block_p2),
`endif
    .health_1      (health_1),
    .health_2      (health_2),
    .state         (state),
    .rounds_1      (rounds_1),
    .rounds_2      (rounds_2),
    .invuln_1      (invuln_1),
    .invuln_2      (invuln_2),
    .ko_pulse      (ko_pulse)
  );

  always #5 clk = ~clk;

  function automatic int dmg(input logic [1:0] a, input logic g);
    int d;
    d = (a == 2'd1) ? 4 : (a == 2'd2) ? 10 : (a == 2'd3) ? 20 : 0;
    return g ? d / 4 : d;
  endfunction

  task automatic model_reset();
    m_hp1 = HMAX; m_hp2 = HMAX;
    m_iv1 = 0; m_iv2 = 0; m_hold = 0;
    m_st = 0; m_r1 = 0; m_r2 = 0; m_ko = 0;
  endtask

  // One clock of game rules, from the inputs seen at the edge.
  task automatic model_step();
    int n_hp1, n_hp2, n_iv1, n_iv2, n_hold, n_st, n_r1, n_r2, n_ko;
    bit a1, a2;
    if (!reset_n) begin
      model_reset();
      return;
    end
    a2 = hit_p1 && attack_p1 != 0 && m_st == 0 && m_iv2 == 0 && m_hp2 > 0;
    a1 = hit_p2 && attack_p2 != 0 && m_st == 0 && m_iv1 == 0 && m_hp1 > 0;
    n_hp2 = a2 ? ((m_hp2 - dmg(attack_p1, block_p2) < 0) ? 0 : m_hp2 - dmg(attack_p1, block_p2)) : m_hp2;
    n_hp1 = a1 ? ((m_hp1 - dmg(attack_p2, block_p1) < 0) ? 0 : m_hp1 - dmg(attack_p2, block_p1)) : m_hp1;
    n_iv2 = (a2 && !block_p2) ? IFR : (frame_tick && m_iv2 > 0) ? m_iv2 - 1 : m_iv2;
    n_iv1 = (a1 && !block_p1) ? IFR : (frame_tick && m_iv1 > 0) ? m_iv1 - 1 : m_iv1;
    n_hold = (frame_tick && m_hold > 0) ? m_hold - 1 : m_hold;
    n_st = m_st; n_r1 = m_r1; n_r2 = m_r2; n_ko = 0;
    if (m_st == 0) begin
      if (m_hp1 == 0 || m_hp2 == 0) begin
        n_ko = 1;
        n_hold = HOLD;
        if (m_hp1 == 0 && m_hp2 == 0) n_st = 3;
        else if (m_hp2 == 0) begin n_st = 1; n_r1 = m_r1 + 1; end
        else begin n_st = 2; n_r2 = m_r2 + 1; end
      end
    end else if (m_st >= 1 && m_st <= 3) begin
      if (m_hold == 0) begin
        if (m_st == 1 && m_r1 == RTW) n_st = 5;
        else if (m_st == 2 && m_r2 == RTW) n_st = 6;
        else begin
          n_st = 0; n_hp1 = HMAX; n_hp2 = HMAX; n_iv1 = 0; n_iv2 = 0;
        end
      end
    end else if (match_restart) begin
      model_reset();
      return;
    end
    m_hp1 = n_hp1; m_hp2 = n_hp2; m_iv1 = n_iv1; m_iv2 = n_iv2;
    m_hold = n_hold; m_st = n_st; m_r1 = n_r1; m_r2 = n_r2; m_ko = n_ko;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_model();
    chk("health_1", 32'(health_1), m_hp1);
    chk("health_2", 32'(health_2), m_hp2);
    chk("state", 32'(state), m_st);
    chk("rounds_1", 32'(rounds_1), m_r1);
    chk("rounds_2", 32'(rounds_2), m_r2);
    chk("invuln_1", 32'(invuln_1), m_iv1 != 0);
    chk("invuln_2", 32'(invuln_2), m_iv2 != 0);
    chk("ko_pulse", 32'(ko_pulse), m_ko);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_hits();
    hit_p1 = 0; hit_p2 = 0; attack_p1 = 0; attack_p2 = 0;
  endtask

  // One accepted hit, then enough ticks for the victim's i-frames to expire.
  task automatic strike(input bit p1, input bit p2, input logic [1:0] atk, input int n);
    repeat (n) begin
      hit_p1 = p1; attack_p1 = p1 ? atk : 2'b00;
      hit_p2 = p2; attack_p2 = p2 ? atk : 2'b00;
      frame_tick = 1;
      cyc();
      clear_hits();
      run(IFR);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_h1"}, 32'(health_1), HMAX);
    chk({tag, "_h2"}, 32'(health_2), HMAX);
    chk({tag, "_st"}, 32'(state), 0);
    chk({tag, "_r1"}, 32'(rounds_1), 0);
    chk({tag, "_r2"}, 32'(rounds_2), 0);
    chk({tag, "_iv"}, 32'({invuln_1, invuln_2}), 0);
    chk({tag, "_ko"}, 32'(ko_pulse), 0);
  endtask

  // Drop health_2 by a final hit to 0, then follow the KO into the hold.
  task automatic ko_p2(input logic [1:0] atk, input int r1_exp);
    hit_p1 = 1; attack_p1 = atk; frame_tick = 0;
    cyc();
    chk("ko_h2_zero", 32'(health_2), 0);
    chk("ko_still_fight", 32'(state), 0);
    clear_hits();
    cyc();
    chk("ko_state", 32'(state), 1);
    chk("ko_pulse_hi", 32'(ko_pulse), 1);
    chk("ko_rounds_1", 32'(rounds_1), r1_exp);
    cyc();
    chk("ko_pulse_lo", 32'(ko_pulse), 0);
  endtask

  initial begin
    reset_n = 0; frame_tick = 0; match_restart = 0;
    block_p1 = 0; block_p2 = 0;
    clear_hits();
    model_reset();
    run(3);
    chk_reset_vals("reset");
    reset_n = 1;

    // Heavy hit lands with one cycle latency.
    hit_p1 = 1; attack_p1 = 2'b11;
    cyc();
    chk("hit_h2", 32'(health_2), 380);
    chk("hit_iv2", 32'(invuln_2), 1);

    // Held hit does nothing until 30 ticks have passed.
    frame_tick = 1;
    run(29);
    chk("hold_h2", 32'(health_2), 380);
    chk("hold_iv2", 32'(invuln_2), 1);
    cyc();
    chk("iv_expire", 32'(invuln_2), 0);
    chk("iv_expire_h2", 32'(health_2), 380);
    frame_tick = 0;
    cyc();
    chk("rehit_h2", 32'(health_2), 360);
    clear_hits();
    frame_tick = 1;
    run(IFR);

    // 360 -> 6, then a 10-damage hit saturates at 0.
    strike(1, 0, 2'b11, 17);
    strike(1, 0, 2'b10, 1);
    strike(1, 0, 2'b01, 1);
    chk("pre_sat_h2", 32'(health_2), 6);
    ko_p2(2'b10, 1);
    frame_tick = 1;
    run(HOLD);
    chk("hold_end_state", 32'(state), 1);
    cyc();
    chk("newround_state", 32'(state), 0);
    chk("newround_h1", 32'(health_1), HMAX);
    chk("newround_h2", 32'(health_2), HMAX);

    // Double KO from 4 HP each.
    strike(1, 1, 2'b11, 19);
    strike(1, 1, 2'b01, 4);
    chk("draw_pre_h1", 32'(health_1), 4);
    chk("draw_pre_h2", 32'(health_2), 4);
    hit_p1 = 1; hit_p2 = 1; attack_p1 = 1; attack_p2 = 1; frame_tick = 0;
    cyc();
    clear_hits();
    cyc();
    chk("draw_state", 32'(state), 3);
    chk("draw_r1", 32'(rounds_1), 1);
    chk("draw_r2", 32'(rounds_2), 0);
    frame_tick = 1;
    run(HOLD + 1);
    chk("draw_next", 32'(state), 0);

    // Second round for player 1 wins the match.
    strike(1, 0, 2'b11, 19);
    ko_p2(2'b11, 2);
    frame_tick = 1;
    run(HOLD + 1);
    chk("match_state", 32'(state), 5);
    repeat (20) begin
      hit_p1 = 1'($urandom); hit_p2 = 1'($urandom);
      attack_p1 = 2'($urandom); attack_p2 = 2'($urandom);
      cyc();
    end
    clear_hits();
    chk("match_sticky", 32'(state), 5);
    chk("match_h1", 32'(health_1), HMAX);
    match_restart = 1;
    cyc();
    match_restart = 0;
    chk_reset_vals("restart");

    // Restart is ignored while fighting.
    match_restart = 1; hit_p1 = 1; attack_p1 = 2'b11;
    cyc();
    match_restart = 0; clear_hits();
    chk("restart_ign_h2", 32'(health_2), 380);
    chk("restart_ign_st", 32'(state), 0);
    run(IFR);

    // Asynchronous reset in the middle of a hold.
    strike(1, 0, 2'b11, 18);
    ko_p2(2'b11, 1);
    frame_tick = 1;
    run(50);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    chk_reset_vals("async_rst");
    cyc();
    reset_n = 1;

`ifdef HRM_BLOCK_EN
    block_p2 = 1; hit_p1 = 1; attack_p1 = 2'b11; frame_tick = 0;
    cyc();
    clear_hits(); block_p2 = 0;
    chk("block_h2", 32'(health_2), 395);
    chk("block_iv2", 32'(invuln_2), 0);
`endif

    // Random play against the model.
    repeat (4000) begin
      hit_p1 = ($urandom_range(0, 3) != 0);
      hit_p2 = ($urandom_range(0, 3) != 0);
      attack_p1 = 2'($urandom);
      attack_p2 = 2'($urandom);
      frame_tick = ($urandom_range(0, 3) != 0);
      match_restart = ($urandom_range(0, 40) == 0);
`ifdef HRM_BLOCK_EN
      block_p1 = ($urandom_range(0, 7) == 0);
      block_p2 = ($urandom_range(0, 7) == 0);
`endif
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
